aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
Iterative AES-128 key schedule. Sits directly upstream of the byte S-box `S`: it feeds RotWord bytes of the current round key into four `S` instances, then consumes their registered outputs to form the next round key. Round keys 0..10 are emitted one per 2 cycles to the round datapath, with a valid strobe.

Parameters:
NR, 10, number of round keys after the initial key; only 10 (AES-128) is supported and elaborated/verified.
KEY_W, 128, key and round-key width; fixed.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request; sampled only when idle
key_in  in  128  cipher key, FIPS-197 byte order; key_in[127:120] is byte 0
busy  out  1  high while an expansion is in progress
rk_valid  out  1  one-cycle pulse; rk_out/rk_round are new this cycle
rk_round  out  4  round index of rk_out, 0..10
rk_out  out  128  round key, same byte order as key_in
done  out  1  one-cycle pulse coincident with the round-10 rk_valid

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE. busy, rk_valid and done are 0. rk_round=0, rk_out=0, internal key register=0, rcon=8'h01.
- Reset mid-operation aborts immediately. No done or rk_valid follows.
- FSM states are IDLE, SUB and MIX. busy = (state != IDLE).
- IDLE & start (cycle 0 edge) causes:
  - key_reg <= key_in and rk_out <= key_in.
  - rk_round <= 0 and rk_valid <= 1.
  - rcon <= 8'h01, round <= 1, state <= SUB.
- SUB:
  - Drive the 4 S inputs with RotWord(w3) = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}.
  - w0..w3 = key_reg[127:96], [95:64], [63:32], [31:0].
  - S registers internally with 1-cycle latency. state <= MIX.
- MIX:
  - t = Sout ^ {rcon, 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - key_reg and rk_out <= {n0,n1,n2,n3}. rk_round <= round. rk_valid <= 1.
  - rcon <= xtime(rcon), i.e. shift left 1, XOR 8'h1b if the bit-7 carry is set.
  - If round==10: done <= 1, state <= IDLE. Else round++, state <= SUB.
- Timing:
  - Round key r is valid in cycle 2r+1 after the start edge: r=0 in cycle 1, r=10 in cycle 21.
  - Total latency from start to done is 21 cycles.
  - busy is high in cycles 1..20 and low in cycle 21.
- start while busy, including during the final MIX, is ignored. There is no queueing, and key_in is only sampled at acceptance.
- start in the same cycle done is high is accepted, because the state is IDLE. Back-to-back expansions are therefore possible with zero gap.
- rk_out holds its last value between pulses. Outputs are registered only; there are no combinational paths from inputs to outputs.
- rcon sequence: 01 02 04 08 10 20 40 80 1b 36.

Decomposition:
- aes_pkg holds:
  - constants KEY_W=128, NR=10, RCON_INIT=8'h01;
  - function xtime(byte), the same 0x11b reduction as xS;
  - FSM state enum {IDLE, SUB, MIX}.
- Sub-module key_sub_word: 32-bit SubWord built from four `S` instances sharing clk, with 1-cycle latency. It is instantiated once here.

Test Plan:
- FIPS-197 A.1 key, start after reset:
  - input key 2b7e151628aed2a6abf7158809cf4f3c;
  - cycle 3: rk_round=1, rk_out=a0fafe1788542cb123a339392a6c7605;
  - cycle 21: rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6, done=1.
- All-zero key:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e;
  - exactly 11 rk_valid pulses, rk_round 0..10 in order.
- start re-asserted in cycles 5 and 20 with a different key_in -> ignored. The output sequence equals the A.1 vectors and busy never drops early.
- start held high continuously -> second expansion accepted in cycle 21, the done cycle; next rk_round=0 in cycle 22.
- rst asserted in cycle 10 -> next cycle busy=0, rk_valid=0, rk_out=0, no done. A fresh start then reproduces the A.1 vectors.
- Idle after reset with start=0 for 50 cycles -> busy, rk_valid and done stay 0; rk_out stays 0.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, FSM states and GF(2^8) helpers for the AES-128 key schedule
package aes_pkg;
  localparam int         KEY_W     = 128;
  localparam int         NR        = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {IDLE, SUB, MIX} state_t;

  // multiply by x modulo x^8+x^4+x^3+x+1 (0x11b)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // inverse as a^254 = a^2 * a^4 * ... * a^128 (zero maps to zero), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/S.sv
// rtl/S.sv - AES byte S-box with a registered output (1-cycle latency)
module S
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] a,
  output logic [7:0] y
);
  always_ff @(posedge clk) begin
    y <= sbox(a);
  end
endmodule

// File: rtl/key_sub_word.sv
// rtl/key_sub_word.sv - 32-bit SubWord from four registered S-boxes
module key_sub_word (
  input  logic        clk,
  input  logic [31:0] word,
  output logic [31:0] sub
);
  for (genvar i = 0; i < 4; i++) begin : g_s
    S u_s (
      .clk (clk),
      .a   (word[8*i +: 8]),
      .y   (sub[8*i +: 8])
    );
  end
endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule, one round key every 2 cycles
module aes_key_expand
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  output logic [3:0]       rk_round,
  output logic [KEY_W-1:0] rk_out,
  output logic             done
);
  state_t           state;
  state_t           state_next;
  logic [KEY_W-1:0] key_reg;
  logic [7:0]       rcon;
  logic [3:0]       round;
  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      sout;
  logic [31:0]      t, n0, n1, n2, n3;
  logic             last_round;

  assign {w0, w1, w2, w3} = key_reg;
  assign last_round       = (round == 4'(NR));

  // S-box inputs follow key_reg every cycle; the result is only consumed in MIX
  key_sub_word u_sub (
    .clk  (clk),
    .word ({w3[23:0], w3[31:24]}),
    .sub  (sout)
  );

  assign t  = sout ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SUB;
      SUB:     state_next = MIX;
      MIX:     state_next = last_round ? IDLE : SUB;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg  <= '0;
      rk_out   <= '0;
      rk_round <= 4'd0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rcon     <= RCON_INIT;
      round    <= 4'd0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_reg  <= key_in;
            rk_out   <= key_in;
            rk_round <= 4'd0;
            rk_valid <= 1'b1;
            rcon     <= RCON_INIT;
            round    <= 4'd1;
          end
        end
        MIX: begin
          key_reg  <= {n0, n1, n2, n3};
          rk_out   <= {n0, n1, n2, n3};
          rk_round <= round;
          rk_valid <= 1'b1;
          rcon     <= xtime(rcon);
          if (last_round) done  <= 1'b1;
          else            round <= round + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed vector bench for aes_key_expand
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] rk;
  } vec_t;

  vec_t a1 [11];
  vec_t zk [3];

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z  = 128'h0;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic lookup(input int kind, input int r, output logic [127:0] v);
    v = '0;
    if (kind == 0) begin
      v = a1[r].rk;
      return 1'b1;
    end
    foreach (zk[i]) if (int'(zk[i].round) == r) begin
      v = zk[i].rk;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // mode: 0 plain, 1 stray starts in cycles 5 and 20, 2 start held high, 3 reset in cycle 10
  task automatic run(input logic [127:0] k, input int kind, input int mode);
    logic [127:0] exp;
    int pulses;
    pulses = 0;
    key_in = k;
    start  = 1'b1;
    step();
    if (mode != 2) start = 1'b0;
    key_in = KEY_Z;
    if (kind == 1) key_in = KEY_A1;
    for (int c = 1; c <= 21; c++) begin
      if (mode == 1) start = (c == 5 || c == 20);
      if (rk_valid) pulses++;
      if (mode == 3 && c > 10) begin
        chk($sformatf("abort_busy_c%0d", c), busy, 0);
        chk($sformatf("abort_valid_c%0d", c), rk_valid, 0);
        chk($sformatf("abort_done_c%0d", c), done, 0);
        if (c == 11) begin
          chk("abort_rk_out", rk_out, 0);
          chk("abort_rk_round", rk_round, 0);
          rst = 1'b0;
        end
      end else begin
        chk($sformatf("rk_valid_c%0d", c), rk_valid, (c % 2 == 1));
        chk($sformatf("busy_c%0d", c), busy, (c <= 20));
        chk($sformatf("done_c%0d", c), done, (c == 21));
        if (c % 2 == 1) begin
          chk($sformatf("rk_round_c%0d", c), rk_round, (c - 1) / 2);
          if (lookup(kind, (c - 1) / 2, exp))
            chk($sformatf("rk_out_r%0d", (c - 1) / 2), rk_out, exp);
        end
      end
      if (mode == 3 && c == 10) rst = 1'b1;
      if (c < 21) step();
    end
    if (mode != 3) chk("pulse_count", pulses, 11);
    if (mode == 2) begin
      step();
      chk("b2b_valid_c22", rk_valid, 1);
      chk("b2b_round_c22", rk_round, 0);
      chk("b2b_rk_out_c22", rk_out, KEY_Z);
      chk("b2b_busy_c22", busy, 1);
      start = 1'b0;
      for (int n = 0; n < 40 && !done; n++) step();
      chk("b2b_done_seen", done, 1);
      chk("b2b_round_final", rk_round, 10);
      chk("b2b_rk_out_final", rk_out, zk[2].rk);
    end
  endtask

  initial begin
    a1[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    a1[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    a1[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    a1[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    a1[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    a1[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    a1[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    a1[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    a1[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    a1[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    a1[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    zk[0]  = '{4'd0,  128'h0};
    zk[1]  = '{4'd1,  128'h62636363626363636263636362636363};
    zk[2]  = '{4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_valid", rk_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_round", rk_round, 0);
    chk("reset_rk_out", rk_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_busy", busy, 0);
      chk("idle_valid", rk_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_rk_out", rk_out, 0);
    end

    run(KEY_A1, 0, 0);
    step();
    run(KEY_Z, 1, 0);
    step();
    run(KEY_A1, 0, 1);
    step();
    run(KEY_A1, 0, 2);
    step();
    run(KEY_A1, 0, 3);
    step();
    run(KEY_A1, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
